gcd_core: RTL

Iterative binary (Stein) greatest-common-divisor engine.
- Consumes `operand_a`/`operand_b` from the SPI memory-mapped wrapper and returns `gcd_o`, which the wrapper sends back on the next SPI frame.
- The wrapper has no start strobe, so the block starts a computation on its own whenever either operand register changes value.
- One shift or subtract per clock; the last result is held stable for SPI readback.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_core_if.sv | 35 +++
 rtl/gcd_operand_monitor.sv | 34 +++
 rtl/gcd_core.sv | 120 ++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the binary GCD engine and its SPI wrapper.
//   state_e        : FSM state encoding used by gcd_core
//   GCD_DATA_WIDTH : default operand/result width, shared with the wrapper
package gcd_pkg;

    localparam int unsigned GCD_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_COMMON = 3'd2,
        S_REDUCE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/gcd_core_if.sv
// Operand/result bundle between the SPI memory-mapped wrapper and gcd_core.
//   operand_a_i / operand_b_i : level-held operands (wrapper -> core)
//   gcd_o                     : last completed result (core -> wrapper)
//   busy_o                    : computation in progress
//   done_o                    : one-cycle pulse when gcd_o is updated
//   master modport: wrapper side; slave modport: core side.
interface gcd_core_if
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GCD_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] operand_a_i;
    logic [DATA_WIDTH-1:0] operand_b_i;
    logic [DATA_WIDTH-1:0] gcd_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output operand_a_i,
        output operand_b_i,
        input  gcd_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  operand_a_i,
        input  operand_b_i,
        output gcd_o,
        output busy_o,
        output done_o
    );

endinterface

// File: rtl/gcd_operand_monitor.sv
// Change detector for a pair of level-held register values.
// Snapshots the inputs every cycle; start_o is high in any cycle where an
// input differs from its snapshot, i.e. a one-cycle pulse per change.
//   clk_i, nreset_i : clock, asynchronous active-low reset
//   a_i, b_i        : monitored values
//   start_o         : change pulse
module gcd_operand_monitor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             start_o
);

    logic [WIDTH-1:0] snap_a_q;
    logic [WIDTH-1:0] snap_b_q;

    // Snapshots reset to zero so nonzero inputs held through reset
    // release trigger a job on the first clock.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            snap_a_q <= '0;
            snap_b_q <= '0;
        end else begin
            snap_a_q <= a_i;
            snap_b_q <= b_i;
        end
    end

    assign start_o = (a_i != snap_a_q) || (b_i != snap_b_q);

endmodule

// File: rtl/gcd_core.sv
// Iterative binary (Stein) GCD engine, one shift or subtract per clock.
// Starts by itself whenever either operand changes; a change mid-job
// aborts and restarts silently. The last result is held on gcd_o.
//   clk_i    : system clock
//   nreset_i : asynchronous active-low reset
//   bus_if   : slave side of gcd_core_if (operands in, gcd/busy/done out)
module gcd_core
    import gcd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GCD_DATA_WIDTH
) (
    input  logic        clk_i,
    input  logic        nreset_i,
    gcd_core_if.slave   bus_if
);

    localparam int unsigned K_W = $clog2(DATA_WIDTH + 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [K_W-1:0]        k_q;
    logic [DATA_WIDTH-1:0] gcd_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  start;
    logic                  finish;
    logic [DATA_WIDTH-1:0] nonzero;
    logic [DATA_WIDTH-1:0] gcd_d;

    gcd_operand_monitor #(
        .WIDTH (DATA_WIDTH)
    ) u_monitor (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .a_i      (bus_if.operand_a_i),
        .b_i      (bus_if.operand_b_i),
        .start_o  (start)
    );

    // S_LOAD and S_REDUCE share one zero-operand exit: k_q is still 0 in
    // S_LOAD, so the shifted result equals the plain nonzero operand there.
    always_comb begin
        nonzero = (a_q == '0) ? b_q : a_q;
        gcd_d   = nonzero << k_q;
        finish  = 1'b0;
        if ((state_q == S_LOAD) || (state_q == S_REDUCE)) begin
            finish = (a_q == '0) || (b_q == '0);
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            gcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // Start wins in every state; an aborted job never completes.
                a_q     <= bus_if.operand_a_i;
                b_q     <= bus_if.operand_b_i;
                k_q     <= '0;
                busy_q  <= 1'b1;
                state_q <= S_LOAD;
            end else if (finish) begin
                gcd_q   <= gcd_d;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    S_LOAD: begin
                        state_q <= S_COMMON;
                    end
                    S_COMMON: begin
                        if (!a_q[0] && !b_q[0]) begin
                            a_q <= a_q >> 1;
                            b_q <= b_q >> 1;
                            k_q <= k_q + K_W'(1);
                        end else begin
                            state_q <= S_REDUCE;
                        end
                    end
                    S_REDUCE: begin
                        if (!a_q[0]) begin
                            a_q <= a_q >> 1;
                        end else if (!b_q[0]) begin
                            b_q <= b_q >> 1;
                        end else if (a_q >= b_q) begin
                            a_q <= a_q - b_q;
                        end else begin
                            b_q <= b_q - a_q;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus_if.gcd_o  = gcd_q;
    assign bus_if.busy_o = busy_q;
    assign bus_if.done_o = done_q;

endmodule
